program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 256, giving the program-memory capacity in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port Start, input, 1 bit, a request to begin a new load.
REQ-005 The block SHALL have port ByteIn, input, 8 bits, the host data byte.
REQ-006 The block SHALL have port ByteValid, input, 1 bit, meaning ByteIn is valid.
REQ-007 The block SHALL have port ByteReady, output, 1 bit, meaning the loader accepts a byte this cycle.
REQ-008 The block SHALL have port MemWrite, output, 1 bit, the program-memory write strobe.
REQ-009 The block SHALL have port MemAddress, output, 32 bits, the program-memory byte address.
REQ-010 The block SHALL have port MemWriteData, output, 32 bits, the assembled instruction word.
REQ-011 The block SHALL have port CoreRun, output, 1 bit; when 1 it releases the processor core from hold.
REQ-012 The block SHALL have port Done, output, 1 bit, meaning the load completed successfully.
REQ-013 The block SHALL have port Error, output, 1 bit, meaning the load was aborted.
REQ-014 The block SHALL have port WordCount, output, 16 bits, the number of words written so far.

Function
REQ-015 The block SHALL use the states IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, RUN and ERR.
REQ-016 A byte SHALL be accepted only on a rising edge where ByteValid=1 and ByteReady=1.
REQ-017 ByteReady SHALL be 1 only in the states LEN_LO, LEN_HI, DATA and CHK.
REQ-018 In IDLE, RUN or ERR, Start=1 SHALL move the block to LEN_LO, clear WordCount, Done and Error, and drop CoreRun; in all other states Start SHALL be ignored.
REQ-019 The load stream SHALL begin with a 16-bit word count N, sent low byte first (LEN_LO), then high byte (LEN_HI).
REQ-020 After LEN_HI, the block SHALL go to ERR if N > MEMORY_DEPTH, to the end-of-load state (REQ-026) if N = 0, and to DATA otherwise.
REQ-021 In DATA, each word SHALL be assembled little-endian from 4 accepted bytes: the first byte goes to bits [7:0] and the fourth to bits [31:24].
REQ-022 After the fourth byte, the block SHALL enter WRITE for exactly one cycle, in which MemWrite=1, MemWriteData holds the word, MemAddress = WordCount*4, and ByteReady=0.
REQ-023 WordCount SHALL increment on the edge that leaves WRITE.
REQ-024 On leaving WRITE, the block SHALL return to DATA if WordCount < N, and otherwise go to the end-of-load state.
REQ-025 MemWrite SHALL be 0 in every state except WRITE.
REQ-026 The end-of-load state SHALL be CHK when the checksum feature is compiled in, and RUN otherwise.
REQ-027 In RUN, CoreRun=1 and Done=1.
REQ-028 In ERR, Error=1 and CoreRun=0.
REQ-029 Stalls of ByteValid SHALL be tolerated indefinitely in any byte-accepting state, with no timeout.
REQ-030 The final word at address (MEMORY_DEPTH-1)*4 SHALL be written with no address wrap.

Reset
REQ-031 While reset=0, the block SHALL be in IDLE with all outputs 0, including CoreRun=0, WordCount=0 and MemWrite=0.
REQ-032 Reset asserted mid-load SHALL abandon the load immediately; no further MemWrite pulse SHALL occur and a partial word SHALL be discarded.

Configuration
REQ-033 With macro LOADER_CHECKSUM_EN defined, the block SHALL expect one checksum byte after the data bytes, in state CHK.
REQ-034 With LOADER_CHECKSUM_EN defined, the checksum byte SHALL equal the XOR of all N*4 data bytes; a match SHALL lead to RUN and a mismatch to ERR.
REQ-035 With LOADER_CHECKSUM_EN undefined, the block SHALL have no CHK state and no checksum logic, and SHALL go straight to RUN.

Verification
REQ-036 Reset, then Start, then bytes 02 00 | 20 08 00 05 | 24 09 00 03 -> exactly two MemWrite pulses: addr 0 with data 0x05000820, then addr 4 with data 0x03000924; WordCount=2; CoreRun=1.
REQ-037 Start, then bytes 01 01 with MEMORY_DEPTH=256 (N=257) -> Error=1, no MemWrite pulse, CoreRun=0.
REQ-038 Start, then bytes 00 00 -> Done=1 with no MemWrite pulse; with LOADER_CHECKSUM_EN defined, a checksum byte 00 is required first.
REQ-039 ByteValid held low for 50 cycles between bytes 2 and 3 of a word -> data unchanged, single MemWrite pulse, ByteReady=0 during WRITE.
REQ-040 Reset asserted after 2 bytes of word 1 -> outputs 0; a subsequent full load writes from address 0 correctly.
REQ-041 With LOADER_CHECKSUM_EN defined, load N=1 with word bytes 11 22 33 44 and checksum 44 -> RUN; the same load with checksum 45 -> Error=1, CoreRun=0.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: receives a length-prefixed word image, writes it to program memory, then releases the core.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int MEMORY_DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic        MemWrite,
   output logic [31:0] MemAddress,
   output logic [31:0] MemWriteData,
   output logic        CoreRun,
   output logic        Done,
   output logic        Error,
   output logic [15:0] WordCount
);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      WRITE,
`ifdef LOADER_CHECKSUM_EN
      CHK,
`endif
      RUN,
      ERR
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t END_STATE = CHK;
`else
   localparam state_t END_STATE = RUN;
`endif

   state_t      state;
   state_t      next_state;
   logic [15:0] len_q;
   logic [15:0] word_count_q;
   logic [31:0] word_q;
   logic [1:0]  byte_idx;
   logic [15:0] len_in;
   logic [15:0] count_next;
   logic        len_too_big;
   logic        can_start;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  checksum_q;
`endif

   assign len_in      = {ByteIn, len_q[7:0]};
   assign count_next  = word_count_q + 16'd1;
   assign len_too_big = {16'd0, len_in} > 32'(MEMORY_DEPTH);
   assign can_start   = Start && (state == IDLE || state == RUN || state == ERR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      ByteReady  = 1'b0;
      case (state)
         IDLE, RUN, ERR: begin
            if (Start) next_state = LEN_LO;
         end
         LEN_LO: begin
            ByteReady = 1'b1;
            if (ByteValid) next_state = LEN_HI;
         end
         LEN_HI: begin
            ByteReady = 1'b1;
            if (ByteValid) begin
               if (len_too_big)        next_state = ERR;
               else if (len_in == '0)  next_state = END_STATE;
               else                    next_state = DATA;
            end
         end
         DATA: begin
            ByteReady = 1'b1;
            if (ByteValid && byte_idx == 2'd3) next_state = WRITE;
         end
         WRITE: begin
            next_state = (count_next < len_q) ? DATA : END_STATE;
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            ByteReady = 1'b1;
            if (ByteValid) next_state = (ByteIn == checksum_q) ? RUN : ERR;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // Datapath: length capture, little-endian word assembly and word counting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_q        <= '0;
         word_count_q <= '0;
         word_q       <= '0;
         byte_idx     <= '0;
      end else begin
         if (can_start) begin
            word_count_q <= '0;
            byte_idx     <= '0;
         end
         if (state == LEN_LO && ByteValid) len_q[7:0] <= ByteIn;
         if (state == LEN_HI && ByteValid) begin
            len_q[15:8] <= ByteIn;
            byte_idx    <= '0;
         end
         if (state == DATA && ByteValid) begin
            word_q[{byte_idx, 3'b000} +: 8] <= ByteIn;
            byte_idx                        <= byte_idx + 2'd1;
         end
         if (state == WRITE) word_count_q <= count_next;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         checksum_q <= '0;
      end else if (can_start) begin
         checksum_q <= '0;
      end else if (state == DATA && ByteValid) begin
         checksum_q <= checksum_q ^ ByteIn;
      end
   end
`endif

   assign MemWrite     = (state == WRITE);
   assign MemAddress   = {14'd0, word_count_q, 2'b00};
   assign MemWriteData = word_q;
   assign CoreRun      = (state == RUN);
   assign Done         = (state == RUN);
   assign Error        = (state == ERR);
   assign WordCount    = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random loads compared against a stream-level reference model.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        MemWrite;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        CoreRun;
   logic        Done;
   logic        Error;
   logic [15:0] WordCount;

   program_loader #(.MEMORY_DEPTH(256)) dut (
      .clk(clk),
      .reset(reset),
      .Start(Start),
      .ByteIn(ByteIn),
      .ByteValid(ByteValid),
      .ByteReady(ByteReady),
      .MemWrite(MemWrite),
      .MemAddress(MemAddress),
      .MemWriteData(MemWriteData),
      .CoreRun(CoreRun),
      .Done(Done),
      .Error(Error),
      .WordCount(WordCount)
   );

   always #5 clk = ~clk;

   int          passCount = 0;
   int          checkCount = 0;
   int          timeouts = 0;
   int          readyDuringWrite = 0;
   logic [63:0] writes[$];
   logic [7:0]  stream[$];
   logic [63:0] expWrites[$];
   logic        expDone;
   logic        expErr;
   logic [15:0] expCount;

   // Every write strobe observed mid-cycle is logged as {address, data}.
   always @(negedge clk) begin
      if (MemWrite === 1'b1) begin
         writes.push_back({MemAddress, MemWriteData});
         if (ByteReady !== 1'b0) readyDuringWrite++;
      end
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
   endtask

   // Reference model: interprets the byte stream directly as length, words and checksum.
   task automatic modelLoad();
      int n;
      logic [7:0] x;
      logic [31:0] w;
      n = {stream[1], stream[0]};
      expWrites.delete();
      expDone = 1'b0;
      expErr = 1'b0;
      expCount = '0;
      x = '0;
      if (n > 256) begin
         expErr = 1'b1;
      end else begin
         for (int i = 0; i < n; i++) begin
            w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            expWrites.push_back({32'(i * 4), w});
         end
         expCount = n[15:0];
`ifdef LOADER_CHECKSUM_EN
         expDone = (stream.size() > 2 + 4 * n) && (stream[2+4*n] == x);
         expErr = !expDone;
`else
         expDone = 1'b1;
`endif
      end
   endtask

   task automatic appendChecksum(input bit good);
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] x;
      x = '0;
      for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
      stream.push_back(good ? x : (x ^ 8'h01));
`else
      if (!good) stream.push_back(8'h00);
`endif
   endtask

   task automatic buildRandom(input int n, input bit good);
      stream.delete();
      stream.push_back(n[7:0]);
      stream.push_back(n[15:8]);
      if (n <= 256) begin
         for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
         appendChecksum(good);
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input int stall);
      int waited;
      ByteValid = 1'b0;
      repeat (stall) @(negedge clk);
      ByteIn = b;
      ByteValid = 1'b1;
      waited = 0;
      while (ByteReady !== 1'b1 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 64) timeouts++;
      else @(negedge clk);
      ByteValid = 1'b0;
   endtask

   task automatic pulseStart();
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
   endtask

   task automatic applyStimulus(input int stallIdx, input int maxStall, input int glitchIdx);
      writes.delete();
      readyDuringWrite = 0;
      timeouts = 0;
      pulseStart();
      for (int i = 0; i < stream.size(); i++) begin
         if (i == glitchIdx) pulseStart();
         sendByte(stream[i], (i == stallIdx) ? 50 : $urandom_range(maxStall, 0));
         if (timeouts != 0) break;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag);
      modelLoad();
      check({tag, "_timeouts"}, 64'(timeouts), 64'd0);
      check({tag, "_nwrites"}, 64'(writes.size()), 64'(expWrites.size()));
      for (int i = 0; i < expWrites.size(); i++)
         check($sformatf("%s_w%0d", tag, i), (i < writes.size()) ? writes[i] : '1, expWrites[i]);
      check({tag, "_count"}, 64'(WordCount), 64'(expCount));
      check({tag, "_done"}, 64'(Done), 64'(expDone));
      check({tag, "_corerun"}, 64'(CoreRun), 64'(expDone));
      check({tag, "_error"}, 64'(Error), 64'(expErr));
      check({tag, "_ready_in_write"}, 64'(readyDuringWrite), 64'd0);
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, "_ready"}, 64'(ByteReady), 64'd0);
      check({tag, "_memwrite"}, 64'(MemWrite), 64'd0);
      check({tag, "_addr"}, 64'(MemAddress), 64'd0);
      check({tag, "_data"}, 64'(MemWriteData), 64'd0);
      check({tag, "_flags"}, 64'({CoreRun, Done, Error}), 64'd0);
      check({tag, "_count"}, 64'(WordCount), 64'd0);
   endtask

   initial begin
      logic [63:0] w;
      reset = 1'b0;
      Start = 1'b0;
      ByteValid = 1'b0;
      ByteIn = '0;
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset");
      reset = 1'b1;
      @(negedge clk);
      checkIdleOutputs("post_reset");

      // Two-word reference program.
      stream = '{8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h03};
      appendChecksum(1'b1);
      applyStimulus(-1, 0, -1);
      checkOutput("two_words");
      w = (writes.size() > 0) ? writes[0] : '1;
      check("two_words_first", w, 64'h0000_0000_0500_0820);
      w = (writes.size() > 1) ? writes[1] : '1;
      check("two_words_second", w, 64'h0000_0004_0300_0924);

      // Oversized length aborts before any data.
      stream = '{8'h01, 8'h01};
      applyStimulus(-1, 0, -1);
      checkOutput("too_long");

      // Empty program.
      stream = '{8'h00, 8'h00};
      appendChecksum(1'b1);
      applyStimulus(-1, 0, -1);
      checkOutput("empty");

      // Long stall in the middle of a word.
      buildRandom(1, 1'b1);
      applyStimulus(4, 0, -1);
      checkOutput("stall50");

      // Start during DATA has no effect.
      buildRandom(2, 1'b1);
      applyStimulus(-1, 2, 5);
      checkOutput("start_ignored");

      // Reset in the middle of the first word.
      buildRandom(2, 1'b1);
      writes.delete();
      pulseStart();
      for (int i = 0; i < 4; i++) sendByte(stream[i], 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checkIdleOutputs("mid_reset");
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("mid_reset_nwrites", 64'(writes.size()), 64'd0);
      buildRandom(3, 1'b1);
      applyStimulus(-1, 1, -1);
      checkOutput("after_reset");

      for (int k = 0; k < 6; k++) begin
         buildRandom($urandom_range(6, 1), 1'b1);
         applyStimulus(-1, 3, -1);
         checkOutput($sformatf("rand%0d", k));
      end

      buildRandom($urandom_range(65535, 257), 1'b1);
      applyStimulus(-1, 0, -1);
      checkOutput("rand_too_long");

      // Full memory: last word lands at (256-1)*4.
      buildRandom(256, 1'b1);
      applyStimulus(-1, 0, -1);
      checkOutput("full");
      w = (writes.size() > 0) ? writes[writes.size()-1] : '1;
      check("full_last_addr", 64'(w[63:32]), 64'd1020);

`ifdef LOADER_CHECKSUM_EN
      stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      applyStimulus(-1, 0, -1);
      checkOutput("sum_good");
      check("sum_good_run", 64'(CoreRun), 64'd1);
      stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      applyStimulus(-1, 0, -1);
      checkOutput("sum_bad");
      check("sum_bad_error", 64'({Error, CoreRun}), 64'b10);
      buildRandom($urandom_range(5, 1), 1'b0);
      applyStimulus(-1, 2, -1);
      checkOutput("sum_rand_bad");
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
